// File: rtl/mem_dump_reader_pkg.sv
// Shared constants and FSM encoding for the MEM debug-bus dump reader.
// Imported by the interface, the top and the bench.
package mem_dbg_pkg;

    localparam int DBG_ADDR_W = 8;
    localparam int DBG_DATA_W = 32;
    localparam int DBG_DEPTH  = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } dbg_state_e;

endpackage

// File: rtl/mem_dump_reader_if.sv
// Debug-bus read port plus the captured-word valid/ready stream.
// master = dump reader side, slave = memory / downstream side.
interface mem_dump_reader_if
    import mem_dbg_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W
);

    logic [31:0]       mem_check_addr;
    logic [DATA_W-1:0] mem_check_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output mem_check_addr,
        input  mem_check_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_addr
    );

    modport slave (
        input  mem_check_addr,
        output mem_check_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_addr
    );

endinterface

// File: rtl/mem_dump_reader.sv
// Walks a contiguous word range over the debug bus and streams
// each captured word out, one word per two cycles at best.
module mem_dump_reader
    import mem_dbg_pkg::*;
#(
    parameter int ADDR_W = DBG_ADDR_W,
    parameter int DATA_W = DBG_DATA_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     word_cnt,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    mem_dump_reader_if.master   bus
);

    localparam logic [ADDR_W:0]   REM_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CUR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    dbg_state_e        state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W:0]   rem;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    // The pointer owns the debug-bus address; upper bits are tied low.
    assign bus.mem_check_addr = {{(32-ADDR_W){1'b0}}, cur};
    assign bus.out_valid      = out_valid;
    assign bus.out_data       = out_data;
    assign bus.out_addr       = out_addr;

    // Dump FSM with pointer/count and registered busy/done/stream outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cur       <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != ST_IDLE) begin
                state     <= ST_IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                rem       <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (word_cnt != '0) begin
                                cur   <= start_addr;
                                rem   <= word_cnt;
                                state <= ST_READ;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_READ: begin
                        out_data  <= bus.mem_check_data;
                        out_addr  <= cur;
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (bus.out_ready) begin
                            out_valid <= 1'b0;
                            rem       <= rem - REM_ONE;
                            if (rem == REM_ONE) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                cur   <= cur + CUR_ONE;
                                state <= ST_READ;
                            end
                        end
                    end
                    ST_DONE: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: queue model of expected words,
// per-cycle compare process, and directed dump scenarios.
module tb_mem_dump_reader;
    import mem_dbg_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] start_addr = '0;
    logic [8:0] word_cnt = '0;
    logic       busy;
    logic       done;

    logic [31:0] dm [256];

    mem_dump_reader_if bus ();

    assign bus.mem_check_data = dm[bus.mem_check_addr[7:0]];

    mem_dump_reader dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .word_cnt   (word_cnt),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Model: words still owed downstream, in order, as {addr, data}.
    logic [39:0] q [$];
    logic [7:0]  log_addr [$];
    logic [31:0] log_data [$];
    int          log_cyc [$];
    int          rise_cyc [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;

    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic        prev_done = 1'b0;
    logic [7:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    // Compare process: checked on the falling edge, away from updates.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk("addr_hi_zero", 64'(bus.mem_check_addr[31:8]), 64'd0);
            chk("done_with_valid", 64'(done & bus.out_valid), 64'd0);
            if (prev_done)
                chk("busy_after_done", 64'(busy), 64'd0);
            if (done) begin
                chk("busy_in_done", 64'(busy), 64'd1);
                chk("drained_at_done", 64'(q.size()), 64'd0);
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (!prev_valid)
                    rise_cyc.push_back(cyc);
                chk("word_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    chk("out_addr", 64'(bus.out_addr), 64'(q[0][39:32]));
                    chk("out_data", 64'(bus.out_data), 64'(q[0][31:0]));
                end
                if (prev_valid && !prev_hs) begin
                    chk("hold_addr", 64'(bus.out_addr), 64'(prev_addr));
                    chk("hold_data", 64'(bus.out_data), 64'(prev_data));
                end
            end
            prev_hs = bus.out_valid && bus.out_ready && !abort;
            if (prev_hs) begin
                if (q.size() > 0)
                    void'(q.pop_front());
                log_addr.push_back(bus.out_addr);
                log_data.push_back(bus.out_data);
                log_cyc.push_back(cyc);
            end
            if (abort && busy)
                q.delete();
            prev_valid = bus.out_valid;
            prev_done  = done;
            prev_addr  = bus.out_addr;
            prev_data  = bus.out_data;
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        rise_cyc.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse from IDLE and record the words it owes.
    task automatic run_dump(input logic [7:0] a, input logic [8:0] n);
        start_addr = a;
        word_cnt   = n;
        start      = 1'b1;
        start_cyc  = cyc;
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] ai;
            ai = 8'((int'(a) + i) % 256);
            q.push_back({ai, dm[ai]});
        end
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++)
            step();
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    int d0;
    int seen_cnt;
    bit seen [256];

    initial begin
        for (int i = 0; i < 256; i++)
            dm[i] = 32'hD000_0000 | (32'(i) * 32'h0001_0101);
        for (int i = 0; i < 4; i++)
            dm[8'h10 + i] = 32'hA0 + 32'(i);
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_bus_addr", 64'(bus.mem_check_addr), 64'd0);
        step();
        step();
        rstn = 1'b1;
        step();

        // 1: basic four-word dump
        clear_log();
        d0 = done_cnt;
        run_dump(8'h10, 9'd4);
        wait_idle(40);
        chk("t1_count", 64'(log_addr.size()), 64'd4);
        if (log_addr.size() == 4) begin
            chk("t1_addr0", 64'(log_addr[0]), 64'h10);
            chk("t1_addr3", 64'(log_addr[3]), 64'h13);
            chk("t1_data0", 64'(log_data[0]), 64'hA0);
            chk("t1_data3", 64'(log_data[3]), 64'hA3);
            chk("t1_rate", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
            chk("t1_rate3", 64'(log_cyc[3] - log_cyc[2]), 64'd2);
        end
        if (rise_cyc.size() > 0)
            chk("t1_first_valid", 64'(rise_cyc[0] - start_cyc), 64'd2);
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_done_cyc", 64'(done_cyc - start_cyc), 64'd9);

        // 2: backpressure
        clear_log();
        d0 = done_cnt;
        bus.out_ready = 1'b0;
        run_dump(8'h40, 9'd2);
        for (int i = 0; i < 10 && !bus.out_valid; i++)
            step();
        chk("t2_valid_seen", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_valid_held", 64'(bus.out_valid), 64'd1);
        end
        chk("t2_none_yet", 64'(log_addr.size()), 64'd0);
        bus.out_ready = 1'b1;
        wait_idle(40);
        chk("t2_count", 64'(log_addr.size()), 64'd2);
        if (log_addr.size() == 2)
            chk("t2_addr1", 64'(log_addr[1]), 64'h41);
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 3: pointer wrap
        clear_log();
        run_dump(8'hFE, 9'd4);
        wait_idle(40);
        chk("t3_count", 64'(log_addr.size()), 64'd4);
        if (log_addr.size() == 4) begin
            chk("t3_addr0", 64'(log_addr[0]), 64'hFE);
            chk("t3_addr1", 64'(log_addr[1]), 64'hFF);
            chk("t3_addr2", 64'(log_addr[2]), 64'h00);
            chk("t3_addr3", 64'(log_addr[3]), 64'h01);
        end

        // 4: empty dump
        clear_log();
        d0 = done_cnt;
        run_dump(8'h33, 9'd0);
        wait_idle(10);
        step();
        chk("t4_no_words", 64'(rise_cyc.size()), 64'd0);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t4_done_lat", 64'((done_cyc - start_cyc) <= 2), 64'd1);
        chk("t4_idle", 64'(busy), 64'd0);

        // 5: abort during the third word
        clear_log();
        d0 = done_cnt;
        run_dump(8'h20, 9'd8);
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid && bus.out_addr == 8'h22)
                break;
            step();
        end
        chk("t5_third_valid", 64'(bus.out_addr), 64'h22);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_valid_off", 64'(bus.out_valid), 64'd0);
        chk("t5_busy_off", 64'(busy), 64'd0);
        step();
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_count", 64'(log_addr.size()), 64'd2);
        clear_log();
        run_dump(8'h30, 9'd3);
        wait_idle(40);
        chk("t5_restart_count", 64'(log_addr.size()), 64'd3);
        chk("t5_restart_done", 64'(done_cnt - d0), 64'd1);

        // 6: async reset mid-dump, ignored start, full-depth dump
        clear_log();
        run_dump(8'h50, 9'd10);
        step();
        step();
        step();
        rstn = 1'b0;
        #1;
        q.delete();
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_data", 64'(bus.out_data), 64'd0);
        chk("t6_rst_addr", 64'(bus.out_addr), 64'd0);
        chk("t6_rst_bus", 64'(bus.mem_check_addr), 64'd0);
        step();
        rstn = 1'b1;
        step();
        clear_log();
        d0 = done_cnt;
        run_dump(8'h80, 9'd256);
        step();
        start_addr = 8'h05;
        word_cnt   = 9'd3;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_idle(700);
        chk("t6_count", 64'(log_addr.size()), 64'd256);
        for (int i = 0; i < 256; i++)
            seen[i] = 1'b0;
        seen_cnt = 0;
        foreach (log_addr[i]) begin
            if (!seen[log_addr[i]])
                seen_cnt++;
            seen[log_addr[i]] = 1'b1;
        end
        chk("t6_distinct", 64'(seen_cnt), 64'd256);
        if (log_addr.size() == 256) begin
            chk("t6_first", 64'(log_addr[0]), 64'h80);
            chk("t6_last", 64'(log_addr[255]), 64'h7F);
        end
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        step();
        chk("t6_final_idle", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
